// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS word width, control tokens, alignment states and token detection
package tmds_pkg;
  localparam int TMDS_WORD_W = 10;
  localparam logic [TMDS_WORD_W-1:0] TOK_CTRL0 = 10'h354;
  localparam logic [TMDS_WORD_W-1:0] TOK_CTRL1 = 10'h0AB;
  localparam logic [TMDS_WORD_W-1:0] TOK_CTRL2 = 10'h154;
  localparam logic [TMDS_WORD_W-1:0] TOK_CTRL3 = 10'h2AB;

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} align_state_t;

  function automatic logic is_ctrl_token(input logic [TMDS_WORD_W-1:0] w);
    return w == TOK_CTRL0 || w == TOK_CTRL1 || w == TOK_CTRL2 || w == TOK_CTRL3;
  endfunction
endpackage

// File: rtl/tmds_lane_align.sv
// tmds_lane_align: one lane's bit history, boundary search FSM and slip; TMDS_ALIGN_ERRCNT_EN adds a loss-of-lock counter
module tmds_lane_align
  import tmds_pkg::*;
#(
  parameter int SEARCH_WINDOW = 1024,
  parameter int LOCK_COUNT    = 8
) (
  input  logic                   clk_125MHz,
  input  logic                   rst_n,
  input  logic [1:0]             d,
  input  logic                   strobe,
  output logic [TMDS_WORD_W-1:0] word,
  output logic                   locked,
  output logic [3:0]             slip
`ifdef TMDS_ALIGN_ERRCNT_EN
  ,
  output logic [7:0]             lol_cnt
`endif
);
  localparam int MISS_W = $clog2(SEARCH_WINDOW + 1);
  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);

  logic [19:0] hist, hist_n;
  logic [TMDS_WORD_W-1:0] cand;
  logic tok, lol;
  logic [3:0] slip_n, slip_adv;
  logic [MISS_W-1:0] miss, miss_n;
  logic [HIT_W-1:0] hit, hit_n;
  align_state_t state, state_n;

  assign hist_n   = {d, hist[19:2]};
  assign cand     = hist_n[slip +: TMDS_WORD_W];
  assign tok      = is_ctrl_token(cand);
  assign slip_adv = slip == 4'd9 ? 4'd0 : slip + 4'd1;
  assign locked   = state == LOCKED;

  // next-state: FSM and counters only move on strobe cycles
  always_comb begin
    state_n = state;
    miss_n  = miss;
    hit_n   = hit;
    slip_n  = slip;
    lol     = 1'b0;
    if (strobe)
      case (state)
        SEARCH:
          if (tok) begin
            state_n = CONFIRM;
            hit_n   = HIT_W'(1);
            miss_n  = '0;
          end else if (miss == MISS_W'(SEARCH_WINDOW - 1)) begin
            slip_n = slip_adv;
            miss_n = '0;
          end else
            miss_n = miss + MISS_W'(1);
        CONFIRM:
          if (!tok) begin
            state_n = SEARCH;
            slip_n  = slip_adv;
            miss_n  = '0;
            hit_n   = '0;
          end else if (hit == HIT_W'(LOCK_COUNT - 1)) begin
            state_n = LOCKED;
            miss_n  = '0;
            hit_n   = '0;
          end else
            hit_n = hit + HIT_W'(1);
        LOCKED:
          if (tok)
            miss_n = '0;
          else if (miss == MISS_W'(SEARCH_WINDOW - 1)) begin
            state_n = SEARCH;
            slip_n  = slip_adv;
            miss_n  = '0;
            lol     = 1'b1;
          end else
            miss_n = miss + MISS_W'(1);
        default: state_n = SEARCH;
      endcase
  end

  // state registers; word is captured from the current slip on every strobe
  always_ff @(posedge clk_125MHz or negedge rst_n)
    if (!rst_n) begin
      hist  <= '0;
      state <= SEARCH;
      miss  <= '0;
      hit   <= '0;
      slip  <= '0;
      word  <= '0;
    end else begin
      hist  <= hist_n;
      state <= state_n;
      miss  <= miss_n;
      hit   <= hit_n;
      slip  <= slip_n;
      if (strobe) word <= cand;
    end

`ifdef TMDS_ALIGN_ERRCNT_EN
  // saturating count of LOCKED to SEARCH drops
  always_ff @(posedge clk_125MHz or negedge rst_n)
    if (!rst_n) lol_cnt <= '0;
    else if (lol && lol_cnt != 8'hFF) lol_cnt <= lol_cnt + 8'd1;
`else
  logic unused_lol;
  assign unused_lol = lol;
`endif
endmodule

// File: rtl/tmds_lane_aligner.sv
// tmds_lane_aligner: TMDS receive front end, polarity fix, 10-bit gearbox and per-lane symbol alignment; TMDS_ALIGN_ERRCNT_EN adds lol_cnt_o
module tmds_lane_aligner
  import tmds_pkg::*;
#(
  parameter int                   NUM_LANES     = 3,
  parameter logic [NUM_LANES-1:0] INV_MASK      = '0,
  parameter int                   SEARCH_WINDOW = 1024,
  parameter int                   LOCK_COUNT    = 8
) (
  input  logic                               clk_125MHz,
  input  logic                               rst_n,
  input  logic [2*NUM_LANES-1:0]             ddr_i,
  output logic [TMDS_WORD_W*NUM_LANES-1:0]   word_o,
  output logic                               valid_o,
  output logic [NUM_LANES-1:0]               locked_o,
  output logic                               all_locked_o,
  output logic [4*NUM_LANES-1:0]             slip_o
`ifdef TMDS_ALIGN_ERRCNT_EN
  ,
  output logic [8*NUM_LANES-1:0]             lol_cnt_o
`endif
);
  logic [2:0] phase;
  logic strobe;

  assign strobe       = phase == 3'd4;
  assign all_locked_o = &locked_o;

  // shared 0..4 phase counter; valid_o follows each strobe by one cycle
  always_ff @(posedge clk_125MHz or negedge rst_n)
    if (!rst_n) begin
      phase   <= '0;
      valid_o <= 1'b0;
    end else begin
      phase   <= strobe ? 3'd0 : phase + 3'd1;
      valid_o <= strobe;
    end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tmds_lane_align #(
      .SEARCH_WINDOW(SEARCH_WINDOW),
      .LOCK_COUNT   (LOCK_COUNT)
    ) u_lane (
      .clk_125MHz(clk_125MHz),
      .rst_n     (rst_n),
      .d         (ddr_i[2*i +: 2] ^ {2{INV_MASK[i]}}),
      .strobe    (strobe),
      .word      (word_o[TMDS_WORD_W*i +: TMDS_WORD_W]),
      .locked    (locked_o[i]),
      .slip      (slip_o[4*i +: 4])
`ifdef TMDS_ALIGN_ERRCNT_EN
      ,
      .lol_cnt   (lol_cnt_o[8*i +: 8])
`endif
    );
  end
endmodule

// File: doc/tmds_lane_aligner.md
# tmds_lane_aligner

Parametrised TMDS receive front end. It takes per-lane 2-bit DDR sample pairs from the IDDRX1F primitives on the pixel-times-5 clock and applies per-lane polarity correction. It gearboxes the samples into 10-bit symbols and finds the symbol boundary per lane by bit-slipping until HDMI control tokens are seen consistently. It sits between the input IDDRs and any TMDS decoder or retransmit path; aligned words are presented once per pixel clock with a valid strobe.

## Interface
- NUM_LANES, 3, number of TMDS data lanes.
- INV_MASK, 0, NUM_LANES bits; bit i set = lane i samples inverted before use.
- SEARCH_WINDOW, 1024, words without any control token before slipping or dropping lock (≥ one video line).
- LOCK_COUNT, 8, consecutive control tokens required to declare lock.

- clk_125MHz  in  1  bit clock (5× pixel), all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ddr_i  in  2*NUM_LANES  lane i = ddr_i[2i+1:2i]; bit 2i received first.
- word_o  out  10*NUM_LANES  aligned symbol per lane, LSB = first bit on wire.
- valid_o  out  1  one-cycle strobe, word_o updated this cycle.
- locked_o  out  NUM_LANES  per-lane lock.
- all_locked_o  out  1  AND of locked_o.
- slip_o  out  4*NUM_LANES  current bit offset per lane, 0..9.

## Operation
- Polarity: d = ddr_i XOR per-lane INV_MASK bit replicated ×2.
- History per lane: 20-bit hist <= {d[1], d[0], hist[19:2]} every cycle.
- Shared phase counter 0..4, wraps 4→0. The cycle with phase==4 is a strobe cycle. Candidate word = hist[slip +: 10] taken from hist including the current cycle's shift.
- Token set: 0x354, 0x0AB, 0x154, 0x2AB. Any other value is a non-token.
- Per-lane FSM evaluated only on strobe cycles:
  - SEARCH: token → CONFIRM, hit=1, miss=0. Non-token → miss++. When miss reaches SEARCH_WINDOW: slip advances, miss=0.
  - CONFIRM: token → hit++. When hit reaches LOCK_COUNT → LOCKED, miss=0. Non-token → SEARCH, slip advances, miss=0.
  - LOCKED: token → miss=0. Non-token → miss++. When miss reaches SEARCH_WINDOW → SEARCH, slip advances, miss=0.
- Slip advance: 9 wraps to 0. The new slip is used from the next strobe; history is not flushed.
- word_o is always driven from the current slip, locked or not.
- miss counter width is clog2(SEARCH_WINDOW+1); hit counter width is clog2(LOCK_COUNT+1). Neither counter may wrap.

## Timing
- Reset values: word_o=0, valid_o=0, locked_o=0, all_locked_o=0, slip_o=0, phase=0, all FSMs in SEARCH, counters 0.
- valid_o and word_o are registered. They are asserted or updated the cycle after a strobe cycle, so valid_o has a period of exactly 5 cycles.
- Latency from the last sample pair of a symbol (at ddr_i) to word_o is 1 cycle.
- locked_o and slip_o update on the same edge as word_o for the strobe that caused the change.
- Reset asserted mid-word: all state clears immediately. After release, the first valid_o is 5 cycles after the first clock edge.
- Lanes are fully independent; there is no inter-lane deskew.

## Configuration
- TMDS_ALIGN_ERRCNT_EN defined: adds port lol_cnt_o, out, 8*NUM_LANES. Each lane has an 8-bit count of LOCKED→SEARCH transitions, saturating at 255 and reset to 0.
- TMDS_ALIGN_ERRCNT_EN undefined: port and counters are absent. All other behaviour is identical.

## Structure
- Package tmds_pkg: TMDS_WORD_W=10, the four token constants, the align-state enum (SEARCH, CONFIRM, LOCKED), and an is_ctrl_token function.
- Sub-module tmds_lane_align: one lane's history, FSM, counters and slip. It is instantiated NUM_LANES times by a generate loop. The phase counter and valid_o live in the top.

## Test plan
- Reset: hold rst_n=0 with random ddr_i, then release → all outputs 0; valid_o first pulses 5 cycles after release, then every 5 cycles.
- Repeating 0x354 with a 3-bit offset on lane 1 → locked_o[1]=1 within 3*SEARCH_WINDOW+LOCK_COUNT words; slip_o[7:4]=3; word_o[19:10]=0x354.
- INV_MASK=3'b001, lane 0 fed with the complement of a 0x2AB stream at offset 0 → lane 0 locks with slip 0 and word_o[9:0]=0x2AB.
- Abort: 5 tokens 0x154 then one 0x1F0 at the correct offset → no lock; slip increments by 1; FSM back in SEARCH.
- Loss of lock: locked lane receives 1024 consecutive 0x1F0 words → locked_o drops on the 1024th strobe; slip advances by 1. With TMDS_ALIGN_ERRCNT_EN, lol_cnt_o increments to 1 and saturates at 255 after 300 repetitions.
- Token every 800 words (one per line) while locked → lock held indefinitely; all_locked_o=1 once all 3 lanes are locked.
